// File: rtl/mux2_reg_if.sv
// mux2_reg_if: data/select/enable inputs and registered status outputs of mux2_reg.
// Optional parity output y_par is present only when MUX2_REG_PARITY_EN is defined.
interface mux2_reg_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             sel_q;
  logic [CNT_W-1:0] swcnt;
`ifdef MUX2_REG_PARITY_EN
  logic             y_par;

  modport master (
    output en, a, b, s,
    input  y, y_valid, sel_q, swcnt, y_par
  );
  modport slave (
    input  en, a, b, s,
    output y, y_valid, sel_q, swcnt, y_par
  );
`else
  modport master (
    output en, a, b, s,
    input  y, y_valid, sel_q, swcnt
  );
  modport slave (
    input  en, a, b, s,
    output y, y_valid, sel_q, swcnt
  );
`endif
endinterface

// File: rtl/mux2_reg.sv
// mux2_reg: registered 2:1 mux with select copy, valid flag and saturating
// select-toggle counter. Define MUX2_REG_PARITY_EN to add the registered
// parity output y_par (XOR of the value loaded into y).
module mux2_reg #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst,   // asynchronous, active-low
  mux2_reg_if.slave bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MUX2_REG_PARITY_EN
  logic             par_q, par_d;
`endif

  // Next state: capture on enable; count a select change only against a valid prior capture.
  always_comb begin
    y_d     = y_q;
    s_d     = s_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (bus.en) begin
      y_d     = bus.s ? bus.b : bus.a;
      s_d     = bus.s;
      valid_d = 1'b1;
      if (valid_q && (bus.s != s_q) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
`ifdef MUX2_REG_PARITY_EN
    par_d = ^y_d;
`endif
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef MUX2_REG_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
`ifdef MUX2_REG_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = valid_q;
  assign bus.sel_q   = s_q;
  assign bus.swcnt   = cnt_q;
`ifdef MUX2_REG_PARITY_EN
  assign bus.y_par   = par_q;
`endif

endmodule

// File: tb/tb_mux2_reg.sv
// tb_mux2_reg: directed, table-driven bench for mux2_reg. Uses a 1-bit instance
// with a 2-bit counter (saturation) and a 4-bit instance (bitwise select, parity).
module tb_mux2_reg;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mux2_reg_if #(.WIDTH(1), .CNT_W(2)) if1 ();
  mux2_reg_if #(.WIDTH(4), .CNT_W(8)) if4 ();

  mux2_reg #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  mux2_reg #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic y;
  } vec_t;

  vec_t vecs[8];
  int   exp_cnt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " y"},       32'(if1.y),       32'd0);
    check({tag, " y_valid"}, 32'(if1.y_valid), 32'd0);
    check({tag, " sel_q"},   32'(if1.sel_q),   32'd0);
    check({tag, " swcnt"},   32'(if1.swcnt),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // {a, b, s, expected y}
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
    exp_cnt = '{0, 1, 2, 3, 3, 3};

    rst = 1'b0;
    if1.en = 1'b1; if1.a = 1'b0; if1.b = 1'b0; if1.s = 1'b0;
    if4.en = 1'b0; if4.a = 4'h0; if4.b = 4'h0; if4.s = 1'b0;

    // Reset held: outputs stay cleared whatever the inputs do.
    for (int i = 0; i < 8; i++) begin
      if1.a = i[0]; if1.b = i[1]; if1.s = i[2];
      @(negedge clk);
      check_reset_vals("rst_held");
    end

    // Functional sweep, one vector per clock.
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if1.a = vecs[i].a; if1.b = vecs[i].b; if1.s = vecs[i].s;
      @(negedge clk);
      check($sformatf("sweep%0d y", i),     32'(if1.y),       32'(vecs[i].y));
      check($sformatf("sweep%0d valid", i), 32'(if1.y_valid), 32'd1);
      check($sformatf("sweep%0d sel_q", i), 32'(if1.sel_q),   32'(vecs[i].s));
    end
    // Single 0->1 select change inside the sweep.
    check("sweep swcnt", 32'(if1.swcnt), 32'd1);

    // Asynchronous reset between clock edges with y=1.
    check("pre_async y", 32'(if1.y), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    check_reset_vals("async_held");
    rst = 1'b1;

    // Enable hold: capture y=1 then hold with en=0.
    if1.en = 1'b1; if1.a = 1'b1; if1.b = 1'b0; if1.s = 1'b0;
    @(negedge clk);
    check("hold_cap y",     32'(if1.y),       32'd1);
    check("hold_cap valid", 32'(if1.y_valid), 32'd1);
    if1.en = 1'b0; if1.a = 1'b0; if1.s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d y", i),     32'(if1.y),       32'd1);
      check($sformatf("hold%0d valid", i), 32'(if1.y_valid), 32'd0);
      check($sformatf("hold%0d sel_q", i), 32'(if1.sel_q),   32'd0);
      check($sformatf("hold%0d swcnt", i), 32'(if1.swcnt),   32'd0);
    end

    // Toggle counter with 2-bit saturation, starting from reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    if1.en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if1.s = k[0];
      @(negedge clk);
      check($sformatf("toggle%0d swcnt", k), 32'(if1.swcnt), 32'(exp_cnt[k]));
    end

    // Reset asserted coincident with a rising edge wins.
    if1.a = 1'b1; if1.b = 1'b1; if1.s = 1'b0;
    @(posedge clk);
    rst = 1'b0;
    #1 check_reset_vals("coincident");
    @(negedge clk);
    rst = 1'b1;

    // Wide instance: bitwise select and optional parity.
    if4.en = 1'b1; if4.a = 4'b1011; if4.b = 4'b0110; if4.s = 1'b0;
    @(negedge clk);
    check("w4 s0 y", 32'(if4.y), 32'hB);
`ifdef MUX2_REG_PARITY_EN
    check("w4 s0 y_par", 32'(if4.y_par), 32'd1);
`endif
    if4.s = 1'b1;
    @(negedge clk);
    check("w4 s1 y", 32'(if4.y), 32'h6);
`ifdef MUX2_REG_PARITY_EN
    check("w4 s1 y_par", 32'(if4.y_par), 32'd0);
`endif
    check("w4 swcnt", 32'(if4.swcnt), 32'd1);
    if4.en = 1'b0; if4.b = 4'b0111;
    @(negedge clk);
    check("w4 hold y", 32'(if4.y), 32'h6);
`ifdef MUX2_REG_PARITY_EN
    check("w4 hold y_par", 32'(if4.y_par), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
